// File: rtl/alu_exec_stage.sv
// ALU execute stage: computes ADD/SUB/MOVZ/ZTEST results into a single-entry
// valid/ready output register and maintains the architectural NZCV flags.
module alu_exec_stage #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_flush,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [3:0]        i_alu_op,
  input  logic [DATA_W-1:0] i_op_a,
  input  logic [DATA_W-1:0] i_op_b,
  input  logic [15:0]       i_imm16,
  input  logic [1:0]        i_hw,
  input  logic              i_set_flags,
  input  logic [4:0]        i_rd,
  input  logic              i_reg_write,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_out_result,
  output logic [4:0]        o_out_rd,
  output logic              o_out_reg_write,
  output logic              o_out_zero,
  output logic [3:0]        o_flags_nzcv
);

  localparam logic [3:0] OP_NOP   = 4'b0000;
  localparam logic [3:0] OP_MOVZ  = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_ZTEST = 4'b0111;

  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_result;
  logic [4:0]        r_out_rd;
  logic              r_out_reg_write;
  logic              r_out_zero;
  logic [3:0]        r_flags_nzcv;

  logic              w_in_ready;
  logic              w_accept;
  logic [DATA_W:0]   w_add_sum;
  logic [DATA_W:0]   w_sub_sum;
  logic [DATA_W-1:0] w_movz;
  logic [DATA_W-1:0] w_result;
  logic              w_reg_write;
  logic              w_zero;
  logic              w_flag_upd;
  logic [3:0]        w_nzcv;

  assign w_in_ready = !i_flush && (!r_out_valid || i_out_ready);
  assign w_accept   = i_in_valid && w_in_ready;

  // Subtraction as a + ~b + 1 so the carry-out directly gives the "no borrow" C flag.
  assign w_add_sum = {1'b0, i_op_a} + {1'b0, i_op_b};
  assign w_sub_sum = {1'b0, i_op_a} + {1'b0, ~i_op_b} + {{DATA_W{1'b0}}, 1'b1};
  assign w_movz    = {{(DATA_W-16){1'b0}}, i_imm16} << {i_hw, 4'b0000};

  always_comb begin
    w_result    = '0;
    w_reg_write = i_reg_write;
    case (i_alu_op)
      OP_MOVZ:  w_result = w_movz;
      OP_ADD:   w_result = w_add_sum[DATA_W-1:0];
      OP_SUB:   w_result = w_sub_sum[DATA_W-1:0];
      OP_ZTEST: w_result = i_op_a;
      default: begin
        w_result    = '0;
        w_reg_write = 1'b0;
      end
    endcase
  end

  assign w_zero = (w_result == '0);

  always_comb begin
    w_nzcv     = r_flags_nzcv;
    w_flag_upd = w_accept && i_set_flags &&
                 ((i_alu_op == OP_ADD) || (i_alu_op == OP_SUB));
    if (i_alu_op == OP_ADD) begin
      w_nzcv = {w_result[DATA_W-1], w_zero, w_add_sum[DATA_W],
                (i_op_a[DATA_W-1] == i_op_b[DATA_W-1]) &&
                (w_result[DATA_W-1] != i_op_a[DATA_W-1])};
    end else begin
      w_nzcv = {w_result[DATA_W-1], w_zero, w_sub_sum[DATA_W],
                (i_op_a[DATA_W-1] != i_op_b[DATA_W-1]) &&
                (w_result[DATA_W-1] != i_op_a[DATA_W-1])};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid     <= 1'b0;
      r_out_result    <= '0;
      r_out_rd        <= '0;
      r_out_reg_write <= 1'b0;
      r_out_zero      <= 1'b0;
    end else if (i_flush) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid     <= 1'b1;
      r_out_result    <= w_result;
      r_out_rd        <= i_rd;
      r_out_reg_write <= w_reg_write;
      r_out_zero      <= w_zero;
    end else if (i_out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags_nzcv <= 4'b0000;
    end else if (w_flag_upd) begin
      r_flags_nzcv <= w_nzcv;
    end
  end

  assign o_in_ready      = w_in_ready;
  assign o_out_valid     = r_out_valid;
  assign o_out_result    = r_out_result;
  assign o_out_rd        = r_out_rd;
  assign o_out_reg_write = r_out_reg_write;
  assign o_out_zero      = r_out_zero;
  assign o_flags_nzcv    = r_flags_nzcv;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: directed vector table, hand-written handshake
// sequences, and randomized traffic against an arithmetic reference model.
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, in_valid, in_ready;
  logic [3:0]  alu_op;
  logic [63:0] op_a, op_b;
  logic [15:0] imm16;
  logic [1:0]  hw;
  logic        set_flags, reg_write;
  logic [4:0]  rd;
  logic        out_valid, out_ready, out_reg_write, out_zero;
  logic [63:0] out_result;
  logic [4:0]  out_rd;
  logic [3:0]  flags_nzcv;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic        m_valid;
  logic [63:0] m_result;
  logic [4:0]  m_rd;
  logic        m_rw, m_zero;
  logic [3:0]  m_nzcv;

  always #5 clk = ~clk;

  alu_exec_stage #(.DATA_W(64)) dut (
    .clk(clk), .rst_n(rst_n), .i_flush(flush), .i_in_valid(in_valid),
    .o_in_ready(in_ready), .i_alu_op(alu_op), .i_op_a(op_a), .i_op_b(op_b),
    .i_imm16(imm16), .i_hw(hw), .i_set_flags(set_flags), .i_rd(rd),
    .i_reg_write(reg_write), .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_result(out_result), .o_out_rd(out_rd), .o_out_reg_write(out_reg_write),
    .o_out_zero(out_zero), .o_flags_nzcv(flags_nzcv)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [15:0] imm, input logic [1:0] h,
                       input logic sf, input logic [4:0] d, input logic rw);
    in_valid = v; alu_op = op; op_a = a; op_b = b; imm16 = imm; hw = h;
    set_flags = sf; rd = d; reg_write = rw;
  endtask

  // Result/flags straight from the ISA definitions using wide signed/unsigned arithmetic.
  task automatic ref_exec(output logic [63:0] res, output logic rw_o, output logic fl_en,
                          output logic [3:0] nzcv);
    logic signed [127:0] sa, sb, t;
    logic [127:0] ua, ub;
    logic c, v;
    sa = $signed(op_a); sb = $signed(op_b);
    ua = {64'd0, op_a}; ub = {64'd0, op_b};
    rw_o = reg_write; fl_en = 1'b0; c = 1'b0; v = 1'b0; res = 64'd0;
    case (alu_op)
      4'd1: res = 64'(imm16) * (64'd1 << (16 * hw));
      4'd2: begin
        res = op_a + op_b; fl_en = set_flags;
        c = (ua + ub) >= (128'd1 << 64);
        t = sa + sb;
        v = (t > 128'sh7FFF_FFFF_FFFF_FFFF) || (t < -128'sh8000_0000_0000_0000);
      end
      4'd6: begin
        res = op_a - op_b; fl_en = set_flags;
        c = (op_a >= op_b);
        t = sa - sb;
        v = (t > 128'sh7FFF_FFFF_FFFF_FFFF) || (t < -128'sh8000_0000_0000_0000);
      end
      4'd7: res = op_a;
      default: begin res = 64'd0; rw_o = 1'b0; end
    endcase
    nzcv = {res[63], res == 64'd0, c, v};
  endtask

  task automatic model_reset();
    m_valid = 0; m_result = 0; m_rd = 0; m_rw = 0; m_zero = 0; m_nzcv = 0;
  endtask

  // One clock: check in_ready, advance model, take the edge, check registered outputs.
  task automatic cycle();
    logic rdy, acc, rw_o, fl_en;
    logic [63:0] res;
    logic [3:0] nz;
    #1;
    rdy = !flush && (!m_valid || out_ready);
    chk("in_ready", 64'(in_ready), 64'(rdy));
    acc = in_valid && rdy;
    ref_exec(res, rw_o, fl_en, nz);
    if (flush) m_valid = 0;
    else if (acc) begin
      m_valid = 1; m_result = res; m_rd = rd; m_rw = rw_o; m_zero = (res == 64'd0);
      if (fl_en) m_nzcv = nz;
    end else if (out_ready) m_valid = 0;
    @(posedge clk); #1;
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    chk("flags", 64'(flags_nzcv), 64'(m_nzcv));
    if (m_valid) begin
      chk("out_result", out_result, m_result);
      chk("out_rd", 64'(out_rd), 64'(m_rd));
      chk("out_reg_write", 64'(out_reg_write), 64'(m_rw));
      chk("out_zero", 64'(out_zero), 64'(m_zero));
    end
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return 64'd1;
      2: return 64'hFFFF_FFFF_FFFF_FFFF;
      3: return 64'h8000_0000_0000_0000;
      4: return 64'h7FFF_FFFF_FFFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  typedef struct {
    logic [3:0]  op;
    logic [63:0] a, b;
    logic [15:0] imm;
    logic [1:0]  h;
    logic        sf, rw;
    logic [63:0] e_res;
    logic        e_zero, e_rw;
    logic [3:0]  e_nzcv;
  } vec_t;

  vec_t vt[12];
  logic [63:0] held;
  logic [3:0]  fl_before;

  initial begin
    vt[0]  = '{4'd2, 64'd5, 64'd3, 16'd0, 2'd0, 1'b0, 1'b1, 64'd8, 1'b0, 1'b1, 4'b0000};
    vt[1]  = '{4'd6, 64'd3, 64'd5, 16'd0, 2'd0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 4'b1000};
    vt[2]  = '{4'd6, 64'd5, 64'd5, 16'd0, 2'd0, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0, 4'b0110};
    vt[3]  = '{4'd2, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 16'd0, 2'd0, 1'b1, 1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 4'b1001};
    vt[4]  = '{4'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 16'd0, 2'd0, 1'b1, 1'b1, 64'd0, 1'b1, 1'b1, 4'b0110};
    vt[5]  = '{4'd1, 64'd9, 64'd9, 16'hBEEF, 2'd2, 1'b1, 1'b1, 64'h0000_BEEF_0000_0000, 1'b0, 1'b1, 4'b0110};
    vt[6]  = '{4'd1, 64'd9, 64'd9, 16'hBEEF, 2'd3, 1'b1, 1'b1, 64'hBEEF_0000_0000_0000, 1'b0, 1'b1, 4'b0110};
    vt[7]  = '{4'd7, 64'd0, 64'd7, 16'd0, 2'd0, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 4'b0110};
    vt[8]  = '{4'd7, 64'h10, 64'd0, 16'd0, 2'd0, 1'b0, 1'b0, 64'h10, 1'b0, 1'b0, 4'b0110};
    vt[9]  = '{4'hF, 64'd1, 64'd2, 16'd0, 2'd0, 1'b1, 1'b1, 64'd0, 1'b1, 1'b0, 4'b0110};
    vt[10] = '{4'd0, 64'd1, 64'd2, 16'h1234, 2'd1, 1'b0, 1'b1, 64'd0, 1'b1, 1'b0, 4'b0110};
    vt[11] = '{4'd6, 64'd10, 64'd3, 16'd0, 2'd0, 1'b0, 1'b1, 64'd7, 1'b0, 1'b1, 4'b0110};

    rst_n = 0; flush = 0; out_ready = 1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    // directed table, one op per cycle with downstream always ready
    foreach (vt[i]) begin
      drive(1, vt[i].op, vt[i].a, vt[i].b, vt[i].imm, vt[i].h, vt[i].sf, 5'(i + 2), vt[i].rw);
      cycle();
      chk($sformatf("vec%0d_result", i), out_result, vt[i].e_res);
      chk($sformatf("vec%0d_zero", i), 64'(out_zero), 64'(vt[i].e_zero));
      chk($sformatf("vec%0d_rw", i), 64'(out_reg_write), 64'(vt[i].e_rw));
      chk($sformatf("vec%0d_nzcv", i), 64'(flags_nzcv), 64'(vt[i].e_nzcv));
      chk($sformatf("vec%0d_rd", i), 64'(out_rd), 64'(i + 2));
    end

    // backpressure: hold 3 cycles, then consume and accept in the same edge
    out_ready = 0;
    drive(1, 4'd2, 64'd100, 64'd23, 0, 0, 0, 5'd9, 1);
    held = out_result;
    repeat (3) begin
      cycle();
      chk("bp_hold_result", out_result, held);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1;
    #1 chk("bp_release_ready", 64'(in_ready), 64'd1);
    cycle();
    chk("bp_queued_result", out_result, 64'd123);

    // back-to-back stream of 4 ADDs
    for (int k = 0; k < 4; k++) begin
      drive(1, 4'd2, 64'(k * 10), 64'd1, 0, 0, 0, 5'(k), 1);
      cycle();
      chk("stream_valid", 64'(out_valid), 64'd1);
      chk("stream_result", out_result, 64'(k * 10 + 1));
    end

    // flush while valid, with a flag-setting op offered
    fl_before = flags_nzcv;
    drive(1, 4'd6, 64'd1, 64'd2, 0, 0, 1, 5'd4, 1);
    flush = 1;
    #1 chk("flush_in_ready", 64'(in_ready), 64'd0);
    cycle();
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_flags", 64'(flags_nzcv), 64'(fl_before));
    flush = 0;
    cycle();
    chk("post_flush_result", out_result, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("post_flush_flags", 64'(flags_nzcv), 64'(4'b1000));

    // async reset mid-transfer
    drive(1, 4'd2, 64'd5, 64'd6, 0, 0, 1, 5'd7, 1);
    cycle();
    #2 rst_n = 0;
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_result", out_result, 64'd0);
    chk("rst_rd", 64'(out_rd), 64'd0);
    chk("rst_rw", 64'(out_reg_write), 64'd0);
    chk("rst_zero", 64'(out_zero), 64'd0);
    chk("rst_flags", 64'(flags_nzcv), 64'd0);
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1 rst_n = 1;
    drive(1, 4'd2, 64'd5, 64'd3, 0, 0, 0, 5'd2, 1);
    cycle();
    chk("rst_add_result", out_result, 64'd8);
    chk("rst_add_flags", 64'(flags_nzcv), 64'd0);

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [3:0] op;
      case ($urandom_range(0, 6))
        0: op = 4'd0; 1: op = 4'd1; 2, 3: op = 4'd2; 4: op = 4'd6; 5: op = 4'd7;
        default: op = 4'($urandom);
      endcase
      drive($urandom_range(0, 3) != 0, op, pick(), pick(), 16'($urandom), 2'($urandom),
            1'($urandom), 5'($urandom), 1'($urandom));
      flush = ($urandom_range(0, 9) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Execute stage directly downstream of the ALU control decoder.
- Consumes the 4-bit alu_op code plus register/immediate operands and computes the 64-bit result.
- Holds the result in a single-entry output register with a valid/ready handshake toward memory/writeback.
- Maintains the architectural NZCV flag register and produces the zero-test used to resolve CBZ.

Parameters:
- DATA_W, 64, datapath width; the flag and shift rules below assume 64.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  kill the held result and block acceptance this cycle
- in_valid  in  1  upstream presents an operation
- in_ready  out  1  stage can accept this cycle
- alu_op  in  4  0000 NOP, 0001 MOVZ, 0010 ADD, 0110 SUB, 0111 ZTEST (CBZ); other codes undefined
- op_a  in  DATA_W  first operand (Xn, or Xt for CBZ)
- op_b  in  DATA_W  second operand (Xm or zero-extended immediate)
- imm16  in  16  MOVZ immediate
- hw  in  2  MOVZ shift selector; shift = hw*16
- set_flags  in  1  update NZCV (CMP, SUBS/ADDS)
- rd  in  5  destination register
- reg_write  in  1  destination write enable
- out_valid  out  1  result register holds a live operation
- out_ready  in  1  downstream consumes the result
- out_result  out  DATA_W  registered result
- out_rd  out  5  registered rd
- out_reg_write  out  1  registered write enable
- out_zero  out  1  registered (out_result == 0)
- flags_nzcv  out  4  architectural flags {N,Z,C,V}

Behaviour:
- Reset (async, rst_n low), all outputs cleared immediately: out_valid=0, out_result=0, out_rd=0, out_reg_write=0, out_zero=0, flags_nzcv=4'b0000. Reset mid-operation discards the held result.
- in_ready = !flush && (!out_valid || out_ready). Combinational; no dependence on in_valid.
- Accept = in_valid && in_ready. On accept, the result register loads at the next rising edge: out_valid=1, out_result, out_rd, out_reg_write, out_zero. Latency is one cycle from accept to out_valid.
- No accept and out_valid && out_ready: out_valid becomes 0; other output fields hold their values (don't-care).
- out_valid && !out_ready: all out_* fields are held stable (backpressure). in_ready=0.
- Simultaneous consume and accept: the new operation replaces the old one in the same edge with no bubble. Full throughput is 1 operation per cycle.
- flush: next edge out_valid=0. No accept occurs that cycle. Flags are not modified that cycle.
- Arithmetic per alu_op, all modulo 2^64:
  - ADD: result = a + b.
  - SUB: result = a + ~b + 1.
  - MOVZ: result = zero_extend(imm16) << (hw*16); all other bits 0; op_a/op_b ignored.
  - ZTEST: result = op_a.
  - NOP and undefined codes: result = 0 and out_reg_write forced to 0.
- out_zero = (result == 0) for every op. Writeback/branch logic uses it only for ZTEST.
- Flags update only on accept && set_flags && (alu_op is ADD or SUB); otherwise flags_nzcv holds.
  - set_flags with any other op is ignored.
  - N = result[63]; Z = (result == 0).
  - ADD: C = carry-out of bit 63; V = (a[63]==b[63]) && (result[63]!=a[63]).
  - SUB: C = carry-out of a + ~b + 1, i.e. 1 when a >= b unsigned; V = (a[63]!=b[63]) && (result[63]!=a[63]).
- Flags are written at the same edge the result is registered. flags_nzcv is visible one cycle after accept, independent of out_ready.
- No combinational path from in_* to out_*.

Test Plan:
- Reset and ADD: hold rst_n low mid-transfer -> all outputs 0 and NZCV=0000 asynchronously. After release, ADD a=5, b=3, rd=2, reg_write=1 -> next cycle out_valid=1, out_result=8, out_rd=2, out_zero=0, flags unchanged.
- Flag cases:
  - CMP (SUB, set_flags=1, reg_write=0) a=3, b=5 -> out_result=0xFFFFFFFFFFFFFFFE, NZCV=1000.
  - CMP a=5, b=5 -> out_result=0, out_zero=1, NZCV=0110.
  - ADD set_flags a=0x7FFFFFFFFFFFFFFF, b=1 -> out_result=0x8000000000000000, NZCV=1001.
  - ADD set_flags a=0xFFFFFFFFFFFFFFFF, b=1 -> out_result=0, NZCV=0110.
- MOVZ imm16=0xBEEF, hw=2 -> out_result=0x0000BEEF00000000. hw=3 -> 0xBEEF000000000000. Flags untouched even with set_flags=1.
- ZTEST: op_a=0 -> out_zero=1. op_a=0x10 -> out_zero=0, out_result=0x10. Undefined alu_op=1111 with reg_write=1 -> out_result=0, out_reg_write=0.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs stable throughout. Then out_ready=1 -> the queued op is accepted the same cycle and appears next cycle. Back-to-back stream of 4 ADDs with out_ready=1 -> 4 results on 4 consecutive cycles.
- Flush: with out_valid=1, pulse flush while in_valid=1 and set_flags=1 -> in_ready=0, out_valid=0 next cycle, NZCV unchanged, and the input is accepted on the following cycle.
